// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// a max() used to size the phase counter.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StGap  = 2'd2
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretch_if.sv
// Strobe-in / stretched-pulse-out bundle. master drives strobes and ovf clears,
// slave (the stretcher) returns the pulse and queue status.
interface pulse_stretch_if #(
  parameter int unsigned PEND_W = 3
);
  logic              en;
  logic              clr_ovf;
  logic              out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              ovf;

  modport master (
    output en,
    output clr_ovf,
    input  out,
    input  busy,
    input  pending,
    input  ovf
  );

  modport slave (
    input  en,
    input  clr_ovf,
    output out,
    output busy,
    output pending,
    output ovf
  );
endinterface

// File: rtl/pulse_stretch_sat_counter.sv
// Up/down counter that saturates at zero and all-ones; simultaneous inc/dec holds.
// sat flags an increment that was refused because the counter is full.
module pulse_stretch_sat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] Max = '1;

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (inc && !dec && (count_q != Max)) begin
      count_q <= count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign sat   = inc && !dec && (count_q == Max);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle strobes into HIGH_CYCLES-wide pulses, each followed by a
// GAP_CYCLES low gap; strobes arriving mid-pulse are queued in a saturating counter.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned PEND_W      = 3
) (
  input  logic            clk,
  input  logic            rst,
  pulse_stretch_if.slave  bus
);

  localparam int unsigned CntW = $clog2(max_u(HIGH_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CntW-1:0] HighLoad = CntW'(HIGH_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              out_q;
  logic              ovf_q;
  logic [PEND_W-1:0] pending;
  logic              pend_nz;
  logic              last_gap;
  logic              inc;
  logic              sat;

  assign pend_nz  = |pending;
  assign last_gap = (state_q == StGap) && (cnt_q == '0);
  // On the last gap cycle the dequeue is always requested; with an empty queue
  // plus a strobe the counter holds at zero and the strobe starts the next pulse.
  assign inc      = bus.en && (state_q != StIdle);

  pulse_stretch_sat_counter #(
    .W (PEND_W)
  ) u_pend (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .dec   (last_gap),
    .count (pending),
    .sat   (sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.en) begin
            state_q <= StHigh;
            cnt_q   <= HighLoad;
            out_q   <= 1'b1;
          end
        end
        StHigh: begin
          if (cnt_q == '0) begin
            state_q <= StGap;
            cnt_q   <= GapLoad;
            out_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            if (pend_nz || bus.en) begin
              state_q <= StHigh;
              cnt_q   <= HighLoad;
              out_q   <= 1'b1;
            end else begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          out_q   <= 1'b0;
        end
      endcase

      // A fresh overflow beats a same-cycle clear.
      if (sat) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.out     = out_q;
  assign bus.busy    = (state_q != StIdle) || pend_nz;
  assign bus.pending = pending;
  assign bus.ovf     = ovf_q;

endmodule
